// File: rtl/jk_seq_driver.sv
// jk_seq_driver: drive side of a JK flip-flop link.
// Accepts a WIDTH-bit target Q sequence over valid/ready and issues it LSB first.
// Each clock it registers the j/k excitation that walks an external JK flop to the next target bit.
// It checks the flop's Q feedback two cycles later and counts mismatches (saturating).
module jk_seq_driver #(
  parameter int WIDTH = 8,
  parameter bit XFILL = 1'b0,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic             q_fb,
  output logic             j,
  output logic             k,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CW-1:0]    err_cnt
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] ERR_MAX = {CW{1'b1}};
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] pat_r;
  logic             q_exp_r;
  logic [IW-1:0]    idx_r;
  logic             drain_r;

  // Two-stage check pipeline: stage 0 holds the bit just issued, stage 1
  // holds the bit the flop has just captured and is compared against q_fb.
  logic [1:0]       chk_vld_r;
  logic [1:0]       chk_bit_r;

  logic             cur_bit_s;
  logic [1:0]       exc_s;
  logic             chk_fail_s;
  logic             last_bit_s;

  // JK excitation {j,k} that moves the flop from q to t; free input gets XFILL.
  function automatic logic [1:0] jk_excite(input logic q, input logic t);
    logic [1:0] jk_v;
    case ({q, t})
      2'b00:   jk_v = {1'b0, XFILL};
      2'b01:   jk_v = {1'b1, XFILL};
      2'b10:   jk_v = {XFILL, 1'b1};
      2'b11:   jk_v = {XFILL, 1'b0};
      default: jk_v = 2'b00;
    endcase
    return jk_v;
  endfunction

  // Saturating increment for the mismatch counter.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r_v;
    if (v == ERR_MAX) begin
      r_v = v;
    end else begin
      r_v = v + {{(CW-1){1'b0}}, 1'b1};
    end
    return r_v;
  endfunction

  assign start_ready = (state_r == IDLE);

  // Current target bit, its excitation, and the check-stage comparison.
  always_comb begin
    cur_bit_s  = pat_r[idx_r];
    exc_s      = jk_excite(q_exp_r, cur_bit_s);
    last_bit_s = (idx_r == LAST_IDX);
    if (chk_vld_r[1]) begin
      chk_fail_s = (q_fb != chk_bit_r[1]);
    end else begin
      chk_fail_s = 1'b0;
    end
  end

  // Check pipeline: push one entry per DRIVE cycle, shift every cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      chk_vld_r <= 2'b00;
      chk_bit_r <= 2'b00;
    end else begin
      chk_vld_r <= {chk_vld_r[0], (state_r == DRIVE)};
      chk_bit_r <= {chk_bit_r[0], cur_bit_s};
    end
  end

  // Sequencer FSM with all registered outputs and the mismatch counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= IDLE;
      pat_r    <= {WIDTH{1'b0}};
      q_exp_r  <= 1'b0;
      idx_r    <= {IW{1'b0}};
      drain_r  <= 1'b0;
      j        <= 1'b0;
      k        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= {CW{1'b0}};
    end else begin
      done     <= 1'b0;
      mismatch <= chk_fail_s;
      if (chk_fail_s) begin
        err_cnt <= sat_inc(err_cnt);
      end else begin
        err_cnt <= err_cnt;
      end

      case (state_r)
        IDLE: begin
          j <= 1'b0;
          k <= 1'b0;
          if (start_valid) begin
            pat_r   <= pattern;
            q_exp_r <= q_fb;
            err_cnt <= {CW{1'b0}};
            idx_r   <= {IW{1'b0}};
            busy    <= 1'b1;
            state_r <= DRIVE;
          end else begin
            busy    <= 1'b0;
          end
        end

        DRIVE: begin
          j       <= exc_s[1];
          k       <= exc_s[0];
          // The expected Q follows the target only; q_fb never corrects it.
          q_exp_r <= cur_bit_s;
          if (last_bit_s) begin
            drain_r <= 1'b0;
            state_r <= DRAIN;
          end else begin
            idx_r   <= idx_r + IW'(1);
          end
        end

        DRAIN: begin
          j <= 1'b0;
          k <= 1'b0;
          // Second drain edge coincides with the final check.
          if (drain_r) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            drain_r <= 1'b1;
          end
        end

        default: begin
          j       <= 1'b0;
          k       <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_seq_driver.sv
// Bench for jk_seq_driver: three instances (XFILL/CW variants) share stimulus.
// A sequence-level model predicts outputs; literal checks pin key scenarios.
module tb_jk_seq_driver;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start_valid;
  logic [W-1:0] pattern;
  logic         use_ff;
  logic         force_q;
  logic         ff_q;
  logic         q_fb;

  logic rdy0, j0, k0, busy0, done0, mis0;
  logic rdy1, j1, k1, busy1, done1, mis1;
  logic rdy2, j2, k2, busy2, done2, mis2;
  logic [3:0] err0, err1;
  logic [1:0] err2;

  int n_cmp = 0;
  int n_bad = 0;

  assign q_fb = use_ff ? ff_q : force_q;

  jk_seq_driver #(.WIDTH(W), .XFILL(1'b0), .CW(4)) u0 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(rdy0),
    .pattern(pattern), .q_fb(q_fb), .j(j0), .k(k0), .busy(busy0),
    .done(done0), .mismatch(mis0), .err_cnt(err0));

  jk_seq_driver #(.WIDTH(W), .XFILL(1'b1), .CW(4)) u1 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(rdy1),
    .pattern(pattern), .q_fb(q_fb), .j(j1), .k(k1), .busy(busy1),
    .done(done1), .mismatch(mis1), .err_cnt(err1));

  jk_seq_driver #(.WIDTH(W), .XFILL(1'b0), .CW(2)) u2 (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(rdy2),
    .pattern(pattern), .q_fb(q_fb), .j(j2), .k(k2), .busy(busy2),
    .done(done2), .mismatch(mis2), .err_cnt(err2));

  // Behavioural JK flip-flop driven by instance u0.
  always @(posedge clk) begin
    if (!rst) ff_q <= 1'b0;
    else begin
      case ({j0, k0})
        2'b10:   ff_q <= 1'b1;
        2'b01:   ff_q <= 1'b0;
        2'b11:   ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int cw);
    int mx;
    mx = (1 << cw) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Sequence model: cycle position since transfer decides everything.
  logic         m_started = 1'b0;
  logic         m_busy, m_j, m_k, m_jdc, m_kdc, m_done, m_mis, m_q0;
  logic         m_qp, m_t;
  logic [W-1:0] m_pat;
  int           m_rel, m_errs, m_i;

  always @(posedge clk) begin
    m_started = 1'b1;
    if (!rst) begin
      m_busy = 1'b0; m_j = 1'b0; m_k = 1'b0; m_jdc = 1'b0; m_kdc = 1'b0;
      m_done = 1'b0; m_mis = 1'b0; m_errs = 0; m_rel = 0;
    end else begin
      m_done = 1'b0; m_mis = 1'b0;
      m_j = 1'b0; m_k = 1'b0; m_jdc = 1'b0; m_kdc = 1'b0;
      if (m_busy) begin
        m_rel++;
        if (m_rel <= W) begin
          m_i  = m_rel - 1;
          m_qp = (m_i == 0) ? m_q0 : m_pat[m_i-1];
          m_t  = m_pat[m_i];
          // From Q=0 only J matters (J=target); from Q=1 only K (K=!target).
          if (!m_qp) begin m_j = m_t;  m_kdc = 1'b1; end
          else       begin m_k = !m_t; m_jdc = 1'b1; end
        end
        if (m_rel >= 3 && q_fb !== m_pat[m_rel-3]) begin
          m_mis = 1'b1;
          m_errs++;
        end
        if (m_rel == W + 2) begin
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else if (start_valid) begin
        m_pat  = pattern;
        m_q0   = q_fb;
        m_errs = 0;
        m_rel  = 0;
        m_busy = 1'b1;
      end
    end
  end

  // Every-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (m_started) begin
      chk1("u0.j", j0, m_jdc ? 1'b0 : m_j);
      chk1("u0.k", k0, m_kdc ? 1'b0 : m_k);
      chk1("u0.busy", busy0, m_busy);
      chk1("u0.ready", rdy0, !m_busy);
      chk1("u0.done", done0, m_done);
      chk1("u0.mismatch", mis0, m_mis);
      chkv("u0.err_cnt", 32'(err0), sat(m_errs, 4));
      chk1("u1.j", j1, m_jdc ? 1'b1 : m_j);
      chk1("u1.k", k1, m_kdc ? 1'b1 : m_k);
      chk1("u1.busy", busy1, m_busy);
      chk1("u1.ready", rdy1, !m_busy);
      chk1("u1.done", done1, m_done);
      chk1("u1.mismatch", mis1, m_mis);
      chkv("u1.err_cnt", 32'(err1), sat(m_errs, 4));
      chk1("u2.j", j2, m_jdc ? 1'b0 : m_j);
      chk1("u2.k", k2, m_kdc ? 1'b0 : m_k);
      chk1("u2.busy", busy2, m_busy);
      chk1("u2.ready", rdy2, !m_busy);
      chk1("u2.done", done2, m_done);
      chk1("u2.mismatch", mis2, m_mis);
      chkv("u2.err_cnt", 32'(err2), sat(m_errs, 2));
    end
  end

  // One transaction from an idle negedge; returns at the done-cycle negedge.
  task automatic run_seq(input logic [W-1:0] pat, output int n_done,
                         output logic [15:0] jk0s, output logic [15:0] jk1s,
                         output logic [31:0] mmask);
    n_done = 0; jk0s = 16'h0; jk1s = 16'h0; mmask = 32'h0;
    pattern = pat;
    start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c <= W) begin
        jk0s = {jk0s[13:0], j0, k0};
        jk1s = {jk1s[13:0], j1, k1};
      end
      if (mis0) mmask[c] = 1'b1;
      if (done0) begin
        n_done = c;
        break;
      end
    end
    if (n_done == 0) chkv("done_timeout", 32'(n_done), 32'd10);
  endtask

  int          nd, first, second, ndone;
  logic [15:0] s0, s1;
  logic [31:0] mm;

  initial begin
    rst = 1'b0; start_valid = 1'b0; pattern = 8'h00; use_ff = 1'b0; force_q = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk1("reset_ready", rdy0, 1'b1);
    chk1("reset_busy", busy0, 1'b0);
    chkv("reset_err", 32'(err0), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1: all-zero pattern, q_fb=0
    run_seq(8'h00, nd, s0, s1, mm);
    chkv("t1_latency", 32'(nd), 32'd10);
    chkv("t1_jk", 32'(s0), 32'h0000);
    chkv("t1_err", 32'(err0), 32'd0);

    // 2: real flop in the loop
    use_ff = 1'b1;
    run_seq(8'b1010_1010, nd, s0, s1, mm);
    chkv("t2_jk", 32'(s0), 32'h2666);
    chkv("t2_mismask", mm, 32'h0);
    chkv("t2_err", 32'(err0), 32'd0);

    // 3: XFILL=1 excitation on u1
    use_ff = 1'b0; force_q = 1'b0;
    run_seq(8'h0F, nd, s0, s1, mm);
    chkv("t3_jk_xfill1", 32'(s1), 32'hEAD5);

    // 4: stuck-at-0 feedback, all-ones target
    run_seq(8'hFF, nd, s0, s1, mm);
    chkv("t4_mismask", mm, 32'h7F8);
    chkv("t4_err_cw4", 32'(err0), 32'd8);
    chkv("t4_err_cw2", 32'(err2), 32'd3);
    chkv("t4_model_err", 32'(m_errs), 32'd8);

    // 5: reset at E4 mid-DRIVE
    pattern = 8'hFF; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    chkv("t5_err_before", 32'(err0), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk1("t5_j", j0, 1'b0);
    chk1("t5_k", k0, 1'b0);
    chk1("t5_busy", busy0, 1'b0);
    chk1("t5_ready", rdy0, 1'b1);
    chkv("t5_err", 32'(err0), 32'd0);
    rst = 1'b1;
    ndone = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    chkv("t5_no_done", 32'(ndone), 32'd0);

    // 6: back-to-back transfers with start_valid held
    pattern = 8'h3C; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pattern = 8'hC3;
    first = 0; second = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done0) begin
        if (first == 0) begin
          first = c;
          chk1("t6_ready_in_done", rdy0, 1'b1);
          chkv("t6_err_first", 32'(err0), 32'd4);
        end else begin
          second = c;
          break;
        end
      end else if (first != 0 && c == first + 1) begin
        chk1("t6_busy_again", busy0, 1'b1);
        chkv("t6_err_cleared", 32'(err0), 32'd0);
      end
    end
    start_valid = 1'b0;
    chkv("t6_first_done", 32'(first), 32'd10);
    chkv("t6_second_done", 32'(second), 32'd21);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
